// File: rtl/fetch_redirect.sv
// ----------------------------------------------------------------------------
// fetch_redirect
// Instruction-fetch stage of the 5-stage RV32I pipeline. Owns the PC, runs the
// instruction-memory read handshake, fills the IF/ID register, applies EX-stage
// redirects (taken branch / JAL / JALR), squashes wrong-path fetches and
// parks a fetched word in a one-entry hold buffer while ID is stalled.
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   pcmux_sel, alu_out   redirect select and target from EX
//   stall                IF/ID must hold its contents
//   imem_address/read    fetch request (address stable until imem_resp)
//   imem_rdata/resp      fetch completion (one-cycle pulse)
//   if_id_valid/pc/instr IF/ID pipeline register
//   flush                combinational: a redirect is accepted this cycle
// ----------------------------------------------------------------------------
module fetch_redirect #(
   parameter logic [31:0] RESET_PC  = 32'h4000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  pcmux_sel,
   input  logic [31:0] alu_out,
   input  logic        stall,
   output logic [31:0] imem_address,
   output logic        imem_read,
   input  logic [31:0] imem_rdata,
   input  logic        imem_resp,
   output logic        if_id_valid,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_instr,
   output logic        flush
);

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      DISCARD = 2'd2,
      HOLD    = 2'd3
   } state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_t;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } if_id_t;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] tgt_q, tgt_d;
   fetch_t          hold_q, hold_d;
   if_id_t          if_id_q, if_id_d;

   logic            redirect;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] pc_plus4;
   logic            load_resp;
   logic            load_hold;

   // Redirect decode; 2'b11 is reserved and behaves as sequential fetch.
   always_comb begin
      redirect = (pcmux_sel == 2'b01) || (pcmux_sel == 2'b10);
      target   = (pcmux_sel == 2'b10) ? {alu_out[XLEN-1:1], 1'b0} : alu_out;
      pc_plus4 = pc_q + XLEN'(4);
   end

   // Next-state, PC, target latch and hold buffer.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      tgt_d     = tgt_q;
      hold_d    = hold_q;
      load_resp = 1'b0;
      load_hold = 1'b0;

      unique case (state_q)
         IDLE: begin
            state_d = REQ;
            if (redirect) pc_d = target;
         end
         REQ: begin
            if (imem_resp) begin
               if (redirect) begin
                  pc_d = target;
               end else begin
                  pc_d = pc_plus4;
                  if (stall) begin
                     hold_d  = '{pc: pc_q, instr: imem_rdata};
                     state_d = HOLD;
                  end else begin
                     load_resp = 1'b1;
                  end
               end
            end else if (redirect) begin
               // Request already issued: keep the address, drain it later.
               tgt_d   = target;
               state_d = DISCARD;
            end
         end
         DISCARD: begin
            if (redirect) tgt_d = target;
            if (imem_resp) begin
               pc_d    = redirect ? target : tgt_q;
               state_d = REQ;
            end
         end
         HOLD: begin
            if (redirect) begin
               hold_d  = '{pc: '0, instr: NOP_INSTR};
               pc_d    = target;
               state_d = REQ;
            end else if (!stall) begin
               load_hold = 1'b1;
               state_d   = REQ;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // IF/ID update: redirect > stall > load > bubble.
   always_comb begin
      if_id_d = if_id_q;
      if (redirect) begin
         if_id_d.valid = 1'b0;
         if_id_d.instr = NOP_INSTR;
      end else if (!stall) begin
         if (load_resp) begin
            if_id_d = '{valid: 1'b1, pc: pc_q, instr: imem_rdata};
         end else if (load_hold) begin
            if_id_d = '{valid: 1'b1, pc: hold_q.pc, instr: hold_q.instr};
         end else begin
            if_id_d.valid = 1'b0;
            if_id_d.instr = NOP_INSTR;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         tgt_q   <= '0;
         hold_q  <= '{pc: '0, instr: NOP_INSTR};
         if_id_q <= '{valid: 1'b0, pc: '0, instr: NOP_INSTR};
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
         hold_q  <= hold_d;
         if_id_q <= if_id_d;
      end
   end

   assign imem_read    = (state_q == REQ) || (state_q == DISCARD);
   assign imem_address = pc_q;
   assign if_id_valid  = if_id_q.valid;
   assign if_id_pc     = if_id_q.pc;
   assign if_id_instr  = if_id_q.instr;
   assign flush        = redirect;

endmodule

// File: tb/tb_fetch_redirect.sv
// ----------------------------------------------------------------------------
// tb_fetch_redirect
// Directed stimulus for fetch_redirect with a variable-latency memory, a
// transaction-level reference model compared every cycle, and literal
// expectations for the key scenarios.
// ----------------------------------------------------------------------------
module tb_fetch_redirect;

   localparam logic [31:0] RST_PC = 32'h4000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  pcmux_sel = 2'b00;
   logic [31:0] alu_out = 32'h0;
   logic        stall = 1'b0;
   logic [31:0] imem_address;
   logic        imem_read;
   logic [31:0] imem_rdata = 32'h0;
   logic        imem_resp = 1'b0;
   logic        if_id_valid;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instr;
   logic        flush;

   int total = 0;
   int bad   = 0;

   fetch_redirect dut (
      .clk          (clk),
      .rst          (rst),
      .pcmux_sel    (pcmux_sel),
      .alu_out      (alu_out),
      .stall        (stall),
      .imem_address (imem_address),
      .imem_read    (imem_read),
      .imem_rdata   (imem_rdata),
      .imem_resp    (imem_resp),
      .if_id_valid  (if_id_valid),
      .if_id_pc     (if_id_pc),
      .if_id_instr  (if_id_instr),
      .flush        (flush)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], 16'h0013};
   endfunction

   // Memory: responds in the lat-th cycle a request is visible; inject forces
   // a stray response pulse regardless of imem_read.
   int lat    = 1;
   int cnt    = 0;
   bit inject = 1'b0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt        = 0;
         imem_resp  = 1'b0;
         imem_rdata = 32'h0;
      end else begin
         #1;
         if (imem_resp) cnt = 0;
         if (inject) begin
            imem_resp  = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
         end else if (imem_read) begin
            cnt++;
            imem_resp  = (cnt >= lat);
            imem_rdata = imem_resp ? mem_word(imem_address) : 32'h0;
         end else begin
            cnt        = 0;
            imem_resp  = 1'b0;
            imem_rdata = 32'h0;
         end
      end
   end

   // Reference model: tracks whether fetching has started, whether a word is
   // parked, and whether the outstanding request is on the wrong path.
   bit          m_started = 1'b0;
   bit          m_held    = 1'b0;
   bit          m_wrong   = 1'b0;
   bit          m_v       = 1'b0;
   logic [31:0] m_pc      = RST_PC;
   logic [31:0] m_tgt     = 32'h0;
   logic [31:0] m_hpc     = 32'h0;
   logic [31:0] m_hinstr  = NOP;
   logic [31:0] m_ipc     = 32'h0;
   logic [31:0] m_instr   = NOP;

   always @(posedge clk or negedge rst) begin : model
      logic        redir;
      logic [31:0] tgt;
      logic        fetching;
      if (!rst) begin
         m_started = 1'b0;
         m_held    = 1'b0;
         m_wrong   = 1'b0;
         m_pc      = RST_PC;
         m_v       = 1'b0;
         m_ipc     = 32'h0;
         m_instr   = NOP;
      end else begin
         redir    = (pcmux_sel == 2'b01) || (pcmux_sel == 2'b10);
         tgt      = (pcmux_sel == 2'b10) ? (alu_out & ~32'h1) : alu_out;
         fetching = m_started && !m_held;
         if (redir) begin
            m_v     = 1'b0;
            m_instr = NOP;
         end else if (!stall) begin
            if (fetching && imem_resp && !m_wrong) begin
               m_v = 1'b1; m_ipc = m_pc; m_instr = imem_rdata;
            end else if (m_held) begin
               m_v = 1'b1; m_ipc = m_hpc; m_instr = m_hinstr;
            end else begin
               m_v = 1'b0; m_instr = NOP;
            end
         end
         if (!m_started) begin
            m_started = 1'b1;
            if (redir) m_pc = tgt;
         end else if (m_held) begin
            if (redir) begin
               m_held = 1'b0;
               m_pc   = tgt;
            end else if (!stall) begin
               m_held = 1'b0;
            end
         end else if (m_wrong) begin
            if (redir) m_tgt = tgt;
            if (imem_resp) begin
               m_pc    = m_tgt;
               m_wrong = 1'b0;
            end
         end else if (imem_resp) begin
            if (redir) begin
               m_pc = tgt;
            end else begin
               if (stall) begin
                  m_held   = 1'b1;
                  m_hpc    = m_pc;
                  m_hinstr = imem_rdata;
               end
               m_pc = m_pc + 32'd4;
            end
         end else if (redir) begin
            m_wrong = 1'b1;
            m_tgt   = tgt;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      logic exp_read;
      exp_read = m_started && !m_held;
      check("m_imem_read", imem_read, exp_read);
      if (exp_read) check("m_imem_address", imem_address, m_pc);
      check("m_if_id_valid", if_id_valid, m_v);
      check("m_if_id_pc", if_id_pc, m_ipc);
      check("m_if_id_instr", if_id_instr, m_instr);
      check("m_flush", flush, (pcmux_sel == 2'b01) || (pcmux_sel == 2'b10));
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic reset_dut();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   // Directed vector table run under model checking.
   logic [1:0]  v_sel   [16] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd2, 2'd0,
                                 2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0};
   logic [31:0] v_alu   [16] = '{32'h0, 32'h0, 32'h0, 32'h4000_0100, 32'h0,
                                 32'h4000_0301, 32'h4000_0305, 32'h0, 32'h0, 32'h0,
                                 32'h1234_5678, 32'h0, 32'h0, 32'h4000_0500, 32'h0, 32'h0};
   logic        v_stall [16] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

   initial begin
      int n;
      tick();
      tick();
      check("rst_read", imem_read, 1'b0);
      check("rst_valid", if_id_valid, 1'b0);
      check("rst_if_pc", if_id_pc, 32'h0);
      check("rst_if_instr", if_id_instr, NOP);

      // Sequential fetch, 1-cycle memory.
      lat = 1;
      rst = 1'b1;
      tick();
      check("t1_first_read", imem_read, 1'b1);
      check("t1_first_addr", imem_address, 32'h4000_0000);
      tick();
      check("t1_valid0", if_id_valid, 1'b1);
      check("t1_pc0", if_id_pc, 32'h4000_0000);
      check("t1_instr0", if_id_instr, 32'h0000_0013);
      tick();
      check("t1_pc1", if_id_pc, 32'h4000_0004);
      tick();
      check("t1_pc2", if_id_pc, 32'h4000_0008);
      check("t1_valid2", if_id_valid, 1'b1);

      // Branch taken in the idle cycle after reset; reserved select is sequential.
      reset_dut();
      pcmux_sel = 2'b01; alu_out = 32'h4000_0100;
      #1 check("t2_flush", flush, 1'b1);
      tick();
      pcmux_sel = 2'b00; alu_out = 32'h0;
      check("t2_valid", if_id_valid, 1'b0);
      check("t2_addr", imem_address, 32'h4000_0100);
      tick();
      check("t2_addr_seq", imem_address, 32'h4000_0104);
      pcmux_sel = 2'b11; alu_out = 32'h1234_5678;
      #1 check("t2_rsv_flush", flush, 1'b0);
      tick();
      pcmux_sel = 2'b00; alu_out = 32'h0;
      check("t2_rsv_addr", imem_address, 32'h4000_0108);
      check("t2_rsv_pc", if_id_pc, 32'h4000_0104);

      // PC wraps modulo 2^32.
      reset_dut();
      pcmux_sel = 2'b01; alu_out = 32'hFFFF_FFFC;
      tick();
      pcmux_sel = 2'b00; alu_out = 32'h0;
      check("wrap_addr0", imem_address, 32'hFFFF_FFFC);
      tick();
      check("wrap_addr1", imem_address, 32'h0000_0000);
      check("wrap_if_pc", if_id_pc, 32'hFFFF_FFFC);

      // JALR while a 3-cycle request is outstanding.
      lat = 3;
      reset_dut();
      n = 0;
      while (!(imem_read && imem_address == 32'h4000_0010) && n < 60) begin
         tick(); n++;
      end
      check("t3_reach_0010", 32'(n < 60), 32'd1);
      pcmux_sel = 2'b10; alu_out = 32'h4000_0203;
      #1 check("t3_flush", flush, 1'b1);
      tick();
      pcmux_sel = 2'b00; alu_out = 32'h0;
      check("t3_addr_hold0", imem_address, 32'h4000_0010);
      check("t3_read_hold0", imem_read, 1'b1);
      check("t3_valid", if_id_valid, 1'b0);
      check("t3_if_pc_kept", if_id_pc, 32'h4000_000C);
      tick();
      check("t3_addr_hold1", imem_address, 32'h4000_0010);
      tick();
      check("t3_new_addr", imem_address, 32'h4000_0202);
      check("t3_new_read", imem_read, 1'b1);
      n = 0;
      while (!if_id_valid && n < 20) begin tick(); n++; end
      check("t3_wait_valid", 32'(n < 20), 32'd1);
      check("t3_first_pc", if_id_pc, 32'h4000_0202);
      check("t3_first_instr", if_id_instr, 32'h0202_0013);

      // Stall for 3 cycles as the response for 4000_0008 arrives.
      lat = 1;
      reset_dut();
      tick(); tick(); tick();
      check("t4_addr_0008", imem_address, 32'h4000_0008);
      stall = 1'b1;
      tick();
      check("t4_hold_read0", imem_read, 1'b0);
      check("t4_hold_pc0", if_id_pc, 32'h4000_0004);
      check("t4_hold_valid0", if_id_valid, 1'b1);
      tick();
      check("t4_hold_read1", imem_read, 1'b0);
      inject = 1'b1;
      tick();
      inject = 1'b0;
      stall  = 1'b0;
      check("t4_hold_read2", imem_read, 1'b0);
      check("t4_hold_pc2", if_id_pc, 32'h4000_0004);
      tick();
      check("t4_out_pc", if_id_pc, 32'h4000_0008);
      check("t4_out_instr", if_id_instr, 32'h0008_0013);
      check("t4_out_valid", if_id_valid, 1'b1);
      check("t4_next_addr", imem_address, 32'h4000_000C);
      check("t4_next_read", imem_read, 1'b1);

      // Stall and redirect together while holding.
      reset_dut();
      tick(); tick(); tick();
      stall = 1'b1;
      tick();
      pcmux_sel = 2'b01; alu_out = 32'h4000_0400;
      #1 check("t5_flush", flush, 1'b1);
      tick();
      pcmux_sel = 2'b00; alu_out = 32'h0; stall = 1'b0;
      check("t5_valid", if_id_valid, 1'b0);
      check("t5_addr", imem_address, 32'h4000_0400);
      check("t5_read", imem_read, 1'b1);
      n = 0;
      while (!if_id_valid && n < 20) begin tick(); n++; end
      check("t5_wait_valid", 32'(n < 20), 32'd1);
      check("t5_first_pc", if_id_pc, 32'h4000_0400);

      // Asynchronous reset in the middle of a request.
      lat = 3;
      reset_dut();
      n = 0;
      while (!(if_id_valid && imem_read) && n < 30) begin tick(); n++; end
      check("t6_wait_busy", 32'(n < 30), 32'd1);
      #1 rst = 1'b0;
      #1;
      check("t6_async_read", imem_read, 1'b0);
      check("t6_async_valid", if_id_valid, 1'b0);
      check("t6_async_pc", if_id_pc, 32'h0);
      check("t6_async_instr", if_id_instr, NOP);
      tick();
      tick();
      rst = 1'b1;
      tick();
      check("t6_rel_addr", imem_address, 32'h4000_0000);
      check("t6_rel_read", imem_read, 1'b1);
      n = 0;
      while (!if_id_valid && n < 20) begin tick(); n++; end
      check("t6_wait_valid", 32'(n < 20), 32'd1);
      check("t6_first_pc", if_id_pc, 32'h4000_0000);

      // Mixed vector table, 2-cycle memory.
      lat = 2;
      reset_dut();
      for (int i = 0; i < 16; i++) begin
         pcmux_sel = v_sel[i];
         alu_out   = v_alu[i];
         stall     = v_stall[i];
         tick();
      end
      pcmux_sel = 2'b00; alu_out = 32'h0; stall = 1'b0;
      for (int i = 0; i < 8; i++) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
